alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Initiator side of the ALU interface: accepts register-level ALU commands over a valid/ready handshake and reads operands from a local 32x32 register file.
- Drives OP/A/B into the combinational ALU, captures F and ZF/CF/OF/SF, then writes the result back.
- Sits between the lab instruction front end and the ALU; one command is outstanding at a time.

Parameters:
- NREG, 32, number of architectural registers; index width is 5, and register 0 is hardwired to zero.
- RST_VAL, 32'h0000_0000, reset value of every register-file entry.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command valid.
- in_ready  out  1  sequencer can accept a command.
- in_op  in  4  ALU opcode; legal values are 0x0-0x8 and 0xD.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register for A.
- in_rs2  in  5  source register for B.
- in_use_imm  in  1  when 1, B comes from in_imm instead of rs2.
- in_imm  in  32  immediate operand.
- alu_op  out  4  registered opcode driven to the ALU.
- alu_a  out  32  registered A operand.
- alu_b  out  32  registered B operand.
- alu_f  in  32  ALU result.
- alu_zf, alu_cf, alu_of, alu_sf  in  1 each  ALU flags.
- done  out  1  one-cycle pulse when a command retires.
- err  out  1  one-cycle pulse, coincident with done, when the command had an illegal opcode.
- result  out  32  last retired result, held until the next legal retire.
- flags  out  4  {ZF,CF,OF,SF} of the last legal retire.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  combinational read of the register file; address 0 reads 0.

Behaviour:
- Reset state: state=IDLE, in_ready=1, alu_op/alu_a/alu_b=0, done=0, err=0, result=0, flags=4'b0000, every register=RST_VAL. Register 0 always reads 0.
- FSM states are IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N: latch alu_op<=in_op, alu_a<=R[rs1], alu_b<=(in_use_imm ? in_imm : R[rs2]), and rd. Go to EXEC.
- EXEC (cycle N+1):
  - in_ready=0; ALU inputs stable the whole cycle.
  - Legal opcode, at the end of the cycle: R[rd]<=alu_f (dropped if rd==0), result<=alu_f, flags<={alu_zf,alu_cf,alu_of,alu_sf}.
  - Illegal opcode: no writeback; result and flags unchanged; err flag set for WB.
  - Go to WB.
- WB (cycle N+2): done=1, err=illegal; in_ready=0; go to IDLE.
- Timing:
  - Next accept is possible at edge N+3 (throughput 1 command per 3 cycles).
  - Result is visible on dbg_data in cycle N+2.
- Operand read happens at accept time. Commands that read a register written by the previous command therefore see the updated value, with no hazard.
- Flags are captured for every legal op, including logic and shift ops; the ALU's CF/OF are not masked.
- in_valid held high while in_ready=0 is ignored; in_* may change freely outside the accept edge.
- rst asserted in EXEC or WB: return to IDLE next edge; the pending writeback is discarded; done/err are not asserted; register file is reinitialised.
- alu_op/alu_a/alu_b hold their values in IDLE and WB; they are not cleared after retire.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- When defined, two extra 32-bit output ports are added:
  - perf_retired: counts legal retires, incrementing in the WB cycle.
  - perf_illegal: counts illegal retires.
  - Both reset to 0 on rst and wrap 0xFFFF_FFFF -> 0.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset, then dbg_addr sweep 0..31 -> all reads 0; in_ready=1; flags=0; result=0.
- Imm-add R1=0+0x7FFF_FFFF (op 0x0, rs1=0, use_imm), then R2=R1+1 via imm -> done at accept+2; R2=0x8000_0000; flags={0,0,1,1}.
- R3=0xFFFF_FFFF via imm-add, then op 0x0 R4=R3+R3 -> R4=0xFFFF_FFFE; CF=1; OF=0; SF=1. Then op 0x8 R5=R3-R3 -> R5=0; ZF=1.
- Write to rd=0 with imm 0x1234 -> done=1; dbg_data at address 0 reads 0; result=0x1234.
- Illegal op 0xA with rd=6 -> done=1 and err=1 in the same cycle; R6 unchanged; flags and result unchanged. Under SEQ_PERF_CNT_EN: perf_illegal=1, perf_retired unchanged.
- Accept a command, assert rst in the EXEC cycle -> no done; R[rd] stays 0; in_ready=1 the cycle after reset deasserts. Also: in_valid held high continuously -> exactly one accept per 3 cycles.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Issue sequencer for an external combinational ALU: accepts one register-level command,
// reads operands from a local register file, captures the ALU result/flags and writes back.
// Optional build macro SEQ_PERF_CNT_EN adds retired/illegal event counters.
module alu_issue_seq #(
    parameter int          NREG    = 32,
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic        in_use_imm,
    input  logic [31:0] in_imm,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_f,
    input  logic        alu_zf,
    input  logic        alu_cf,
    input  logic        alu_of,
    input  logic        alu_sf,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic [3:0]  flags,
`ifdef SEQ_PERF_CNT_EN
    output logic [31:0] perf_retired,
    output logic [31:0] perf_illegal,
`endif
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] rf_q [NREG];
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic [31:0] result_q;
    logic [3:0]  flags_q;
    logic        accept;

    function automatic logic is_legal(input logic [3:0] op);
        return (op <= 4'h8) || (op == 4'hD);
    endfunction

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                // A reset landing on the retire cycle suppresses the retire pulses.
                done    = !rst;
                err     = !rst && err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            // Entry 0 is stored as zero so every read path sees the hardwired value.
            for (int i = 0; i < NREG; i++) rf_q[i] <= (i == 0) ? 32'h0 : RST_VAL;
        end else begin
            if (accept) begin
                op_q <= in_op;
                a_q  <= rf_q[in_rs1];
                b_q  <= in_use_imm ? in_imm : rf_q[in_rs2];
                rd_q <= in_rd;
            end
            if (state_q == EXEC) begin
                err_q <= !is_legal(op_q);
                if (is_legal(op_q)) begin
                    if (rd_q != 5'd0) rf_q[rd_q] <= alu_f;
                    result_q <= alu_f;
                    flags_q  <= {alu_zf, alu_cf, alu_of, alu_sf};
                end
            end
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_ret_q, perf_ill_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ret_q <= '0;
            perf_ill_q <= '0;
        end else if (state_q == WB) begin
            if (err_q) perf_ill_q <= perf_ill_q + 32'd1;
            else       perf_ret_q <= perf_ret_q + 32'd1;
        end
    end

    assign perf_retired = perf_ret_q;
    assign perf_illegal = perf_ill_q;
`endif

    assign alu_op   = op_q;
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign result   = result_q;
    assign flags    = flags_q;
    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: supplies a behavioural ALU, keeps an architectural register
// model, and checks handshake timing, writeback, flags and reset behaviour.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        in_use_imm;
    logic [31:0] in_imm;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_f;
    logic        alu_zf, alu_cf, alu_of, alu_sf;
    logic        done, err;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_retired, perf_illegal;
    int unsigned exp_ret = 0, exp_ill = 0;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] mr [32];
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;

    always #5 clk = ~clk;

    alu_issue_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_of(alu_of), .alu_sf(alu_sf),
        .done(done), .err(err), .result(result), .flags(flags),
`ifdef SEQ_PERF_CNT_EN
        .perf_retired(perf_retired), .perf_illegal(perf_illegal),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Returns {F, ZF, CF, OF, SF}; illegal opcodes produce junk so a missed suppression shows.
    function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] f;
        logic        c, o;
        c = 1'b0; o = 1'b0; f = 32'h0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; f = w[31:0]; c = w[32];
                        o = (a[31] == b[31]) && (f[31] != a[31]); end
            4'h1: f = a & b;
            4'h2: f = a | b;
            4'h3: f = a ^ b;
            4'h4: f = a << b[4:0];
            4'h5: f = a >> b[4:0];
            4'h6: f = $signed(a) >>> b[4:0];
            4'h7: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h8: begin f = a - b; c = (a < b);
                        o = (a[31] != b[31]) && (f[31] != a[31]); end
            4'hD: f = b;
            default: begin f = ~a ^ 32'h5A5A_0F0F; c = 1'b1; o = 1'b1; end
        endcase
        return {f, (f == 32'h0), c, o, f[31]};
    endfunction

    always_comb {alu_f, alu_zf, alu_cf, alu_of, alu_sf} = alu_ref(alu_op, alu_a, alu_b);

    function automatic logic [31:0] rd_model(input logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : mr[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mr[i] = 32'h0;
        exp_res = 32'h0;
        exp_fl  = 4'h0;
`ifdef SEQ_PERF_CNT_EN
        exp_ret = 0;
        exp_ill = 0;
`endif
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", {31'h0, in_ready}, 32'd1);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic ui, input logic [31:0] imm);
        logic [31:0] a, b;
        logic [35:0] r;
        logic        legal;
        legal = (op <= 4'h8) || (op == 4'hD);
        a = rd_model(rs1);
        b = ui ? imm : rd_model(rs2);
        r = alu_ref(op, a, b);
        wait_ready();
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = ui; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_op = 4'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_imm = $urandom;
        chk("exec_ready", {31'h0, in_ready}, 32'd0);
        chk("exec_done", {31'h0, done}, 32'd0);
        chk("alu_op", {28'h0, alu_op}, {28'h0, op});
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        if (legal) begin
            if (rd != 5'd0) mr[rd] = r[35:4];
            exp_res = r[35:4];
            exp_fl  = r[3:0];
        end
        @(negedge clk);
        chk("wb_done", {31'h0, done}, 32'd1);
        chk("wb_err", {31'h0, err}, {31'h0, !legal});
        chk("wb_result", result, exp_res);
        chk("wb_flags", {28'h0, flags}, {28'h0, exp_fl});
        dbg_addr = rd;
        #1;
        chk("wb_dbg", dbg_data, rd_model(rd));
`ifdef SEQ_PERF_CNT_EN
        if (legal) exp_ret++; else exp_ill++;
`endif
        @(negedge clk);
        chk("idle_done", {31'h0, done}, 32'd0);
        chk("idle_ready", {31'h0, in_ready}, 32'd1);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_retired", perf_retired, exp_ret);
        chk("perf_illegal", perf_illegal, exp_ill);
`endif
    endtask

    initial begin
        logic [3:0] ill_ops [6];
        logic [3:0] op;
        int         k, acc;
        logic [31:0] r7;
        ill_ops = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hE, 4'hF};

        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_use_imm = 1'b0; in_imm = '0; dbg_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_alu_op", {28'h0, alu_op}, 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("rst_dbg", dbg_data, 32'h0);
        end

        // Signed overflow into the sign bit
        run_cmd(4'h0, 5'd1, 5'd0, 5'd0, 1'b1, 32'h7FFF_FFFF);
        run_cmd(4'h0, 5'd2, 5'd1, 5'd0, 1'b1, 32'h0000_0001);
        chk("r2_value", result, 32'h8000_0000);
        chk("r2_flags", {28'h0, flags}, 32'h3);

        // Carry out, then zero result
        run_cmd(4'h0, 5'd3, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        run_cmd(4'h0, 5'd4, 5'd3, 5'd3, 1'b0, 32'h0);
        chk("r4_value", result, 32'hFFFF_FFFE);
        chk("r4_flags", {28'h0, flags}, 32'h5);
        run_cmd(4'h8, 5'd5, 5'd3, 5'd3, 1'b0, 32'h0);
        chk("r5_zf", {31'h0, flags[3]}, 32'd1);

        // Write to the hardwired zero register
        run_cmd(4'h0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_1234);
        chk("r0_result", result, 32'h0000_1234);

        // Illegal opcode leaves state untouched
        run_cmd(4'hA, 5'd6, 5'd1, 5'd2, 1'b0, 32'h0);
        chk("ill_result", result, 32'h0000_1234);

        // Randomized commands against the model
        for (int i = 0; i < 8; i++) run_cmd(4'h0, 5'(i + 8), 5'd0, 5'd0, 1'b1, $urandom);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                k  = $urandom_range(0, 9);
                op = (k == 9) ? 4'hD : 4'(k);
            end else begin
                op = ill_ops[$urandom_range(0, 5)];
            end
            run_cmd(op, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom);
        end

        // in_valid held high: one accept per three cycles
        r7 = rd_model(5'd7);
        in_op = 4'h0; in_rd = 5'd7; in_rs1 = 5'd7; in_rs2 = 5'd0; in_use_imm = 1'b1; in_imm = 32'd1;
        wait_ready();
        in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready === 1'b1) acc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("throughput", 32'(acc), 32'd10);
        mr[7]   = r7 + 32'd10;
        exp_res = mr[7];
        exp_fl  = alu_ref(4'h0, r7 + 32'd9, 32'd1) & 4'hF;
`ifdef SEQ_PERF_CNT_EN
        exp_ret += 10;
        chk("perf_burst", perf_retired, exp_ret);
`endif
        dbg_addr = 5'd7;
        #1;
        chk("burst_r7", dbg_data, mr[7]);
        chk("burst_result", result, exp_res);
        chk("burst_flags", {28'h0, flags}, {28'h0, exp_fl});

        // Reset during EXEC discards the writeback
        wait_ready();
        in_op = 4'h0; in_rd = 5'd9; in_rs1 = 5'd0; in_use_imm = 1'b1; in_imm = 32'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rexec_done", {31'h0, done}, 32'd0);
        @(negedge clk);
        chk("rexec_ready", {31'h0, in_ready}, 32'd1);
        chk("rexec_done2", {31'h0, done}, 32'd0);
        dbg_addr = 5'd9;
        #1;
        chk("rexec_r9", dbg_data, 32'h0);
        chk("rexec_result", result, 32'h0);
        chk("rexec_flags", {28'h0, flags}, 32'h0);

        // Reset during WB suppresses done/err
        run_cmd(4'h0, 5'd10, 5'd0, 5'd0, 1'b1, 32'h77);
        wait_ready();
        in_op = 4'hB; in_rd = 5'd10; in_rs1 = 5'd10; in_use_imm = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rwb_done", {31'h0, done}, 32'd0);
        chk("rwb_err", {31'h0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        dbg_addr = 5'd10;
        #1;
        chk("rwb_r10", dbg_data, 32'h0);
        chk("rwb_ready", {31'h0, in_ready}, 32'd1);
`ifdef SEQ_PERF_CNT_EN
        chk("rwb_perf", perf_retired, 32'd0);
`endif
        run_cmd(4'h2, 5'd11, 5'd0, 5'd0, 1'b1, 32'hC0DE_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "timeout");
    end

endmodule
